// File: rtl/vga_scanout.sv
// vga_scanout -- parametrised video timing generator and framebuffer scan-out.
//
// Purpose:
//   Free-running h/v counters produce sync and blanking. A fixed-latency
//   external framebuffer is read at the replicated source address. The pixel
//   colour is bit-replicated up to 8 bits per channel. Every video output
//   appears RD_LAT+2 cycles after the counter state that produced it.
//
// Ports:
//   pclk         pixel clock (only clock)
//   reset        synchronous, active-high reset
//   fb_base      source frame base, latched at the last cycle of each frame
//   fb_rd        framebuffer read strobe (high on visible cycles)
//   fb_addr      framebuffer read address (holds while fb_rd is low)
//   fb_data      framebuffer read data, valid RD_LAT cycles after fb_addr
//   hs, vs       horizontal / vertical sync (polarity set by HS_POL / VS_POL)
//   r, g, b      8-bit colour channels, zero outside the visible area
//   VGA_HB/VB    horizontal / vertical blank
//   VGA_DE       data enable = ~(HB|VB)
//   frame_start  one-cycle pulse aligned with the first visible pixel
//
// Optional feature, macro VGA_SCANOUT_DBUF_EN (double buffering):
//   fb_base_alt  alternate buffer base
//   swap_req     level request to flip buffers at the next frame boundary
//   swap_ack     one-cycle pulse when the flip is taken
//   buf_sel      0 = fb_base in use, 1 = fb_base_alt in use

module vga_scanout #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 400,
  parameter int   V_FP     = 12,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 35,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b1,
  parameter int   SCALE_X  = 4,
  parameter int   SCALE_Y  = 4,
  parameter int   BPP      = 8,
  parameter int   ADDR_W   = 18,
  parameter int   RD_LAT   = 1
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fb_base,
`ifdef VGA_SCANOUT_DBUF_EN
  input  logic [ADDR_W-1:0] fb_base_alt,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              buf_sel,
`endif
  output logic              fb_rd,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [BPP-1:0]    fb_data,
  output logic              hs,
  output logic              vs,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              VGA_HB,
  output logic              VGA_VB,
  output logic              VGA_DE,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare count of headroom so every boundary constant fits the width.
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int SXW     = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int SYW     = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam int DLY     = RD_LAT + 2;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE / SCALE_X);

  // Control bundle carried through the delay line.
  localparam int C_HS = 0;
  localparam int C_VS = 1;
  localparam int C_HB = 2;
  localparam int C_VB = 3;
  localparam int C_DE = 4;
  localparam int C_FS = 5;
  localparam logic [5:0] CTRL_IDLE = {1'b0, 1'b0, 1'b1, 1'b1, ~VS_POL, ~HS_POL};

  logic [HW-1:0]     h_cnt_r;
  logic [VW-1:0]     v_cnt_r;
  logic [SXW-1:0]    sub_x_r;
  logic [SYW-1:0]    sub_y_r;
  logic [ADDR_W-1:0] line_base_r;
  logic [ADDR_W-1:0] pix_addr_r;
  logic [ADDR_W-1:0] next_base_s;
  logic              fb_rd_r;
  logic [ADDR_W-1:0] fb_addr_r;
  logic [5:0]        ctrl_s;
  logic [5:0]        ctrl_pipe_r [DLY];
  logic [23:0]       rgb_exp_s;
  logic [23:0]       rgb_r;

  logic h_last_s;
  logic v_last_s;
  logic frame_end_s;
  logic h_vis_s;
  logic v_vis_s;
  logic vis_s;

  assign h_last_s    = (h_cnt_r == HW'(H_TOTAL - 1));
  assign v_last_s    = (v_cnt_r == VW'(V_TOTAL - 1));
  assign frame_end_s = h_last_s & v_last_s;
  assign h_vis_s     = (h_cnt_r < HW'(H_ACTIVE));
  assign v_vis_s     = (v_cnt_r < VW'(V_ACTIVE));
  assign vis_s       = h_vis_s & v_vis_s;

`ifdef VGA_SCANOUT_DBUF_EN
  logic buf_sel_r;
  logic swap_ack_r;
  logic sel_next_s;

  // Base for the next frame: a pending swap selects the other buffer.
  always_comb begin
    sel_next_s  = buf_sel_r ^ swap_req;
    next_base_s = fb_base;
    if (sel_next_s) begin
      next_base_s = fb_base_alt;
    end else begin
      next_base_s = fb_base;
    end
  end

  // Buffer select flips only on the frame-boundary latch cycle.
  always_ff @(posedge pclk) begin
    if (reset) begin
      buf_sel_r  <= 1'b0;
      swap_ack_r <= 1'b0;
    end else begin
      swap_ack_r <= frame_end_s & swap_req;
      if (frame_end_s) begin
        buf_sel_r <= sel_next_s;
      end else begin
        buf_sel_r <= buf_sel_r;
      end
    end
  end

  assign swap_ack = swap_ack_r;
  assign buf_sel  = buf_sel_r;
`else
  // Base for the next frame is always the primary buffer.
  always_comb begin
    next_base_s = fb_base;
  end
`endif

  // Horizontal and vertical position counters.
  always_ff @(posedge pclk) begin
    if (reset) begin
      h_cnt_r <= {HW{1'b0}};
      v_cnt_r <= {VW{1'b0}};
    end else if (h_last_s) begin
      h_cnt_r <= {HW{1'b0}};
      if (v_last_s) begin
        v_cnt_r <= {VW{1'b0}};
      end else begin
        v_cnt_r <= v_cnt_r + VW'(1);
      end
    end else begin
      h_cnt_r <= h_cnt_r + HW'(1);
    end
  end

  // Incremental source address tracking the current counter position.
  // line_base_r holds the address of the current source row; at the frame
  // boundary it is reloaded with the newly latched frame base, so it doubles
  // as the active base register.
  always_ff @(posedge pclk) begin
    if (reset) begin
      sub_x_r     <= {SXW{1'b0}};
      sub_y_r     <= {SYW{1'b0}};
      line_base_r <= fb_base;
      pix_addr_r  <= fb_base;
    end else if (frame_end_s) begin
      sub_x_r     <= {SXW{1'b0}};
      sub_y_r     <= {SYW{1'b0}};
      line_base_r <= next_base_s;
      pix_addr_r  <= next_base_s;
    end else if (h_last_s) begin
      sub_x_r <= {SXW{1'b0}};
      if (v_vis_s && (sub_y_r == SYW'(SCALE_Y - 1))) begin
        sub_y_r     <= {SYW{1'b0}};
        line_base_r <= line_base_r + STRIDE;
        pix_addr_r  <= line_base_r + STRIDE;
      end else if (v_vis_s) begin
        sub_y_r    <= sub_y_r + SYW'(1);
        pix_addr_r <= line_base_r;
      end else begin
        pix_addr_r <= line_base_r;
      end
    end else if (h_vis_s) begin
      if (sub_x_r == SXW'(SCALE_X - 1)) begin
        sub_x_r    <= {SXW{1'b0}};
        pix_addr_r <= pix_addr_r + ADDR_W'(1);
      end else begin
        sub_x_r <= sub_x_r + SXW'(1);
      end
    end else begin
      sub_x_r <= sub_x_r;
    end
  end

  // Read request stage: address holds its last value outside the visible area.
  always_ff @(posedge pclk) begin
    if (reset) begin
      fb_rd_r   <= 1'b0;
      fb_addr_r <= {ADDR_W{1'b0}};
    end else begin
      fb_rd_r <= vis_s;
      if (vis_s) begin
        fb_addr_r <= pix_addr_r;
      end else begin
        fb_addr_r <= fb_addr_r;
      end
    end
  end

  assign fb_rd   = fb_rd_r;
  assign fb_addr = fb_addr_r;

  // Sync, blanking and frame-start flags for the current counter position.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    if ((h_cnt_r >= HW'(H_ACTIVE + H_FP)) && (h_cnt_r < HW'(H_ACTIVE + H_FP + H_SYNC))) begin
      ctrl_s[C_HS] = HS_POL;
    end else begin
      ctrl_s[C_HS] = ~HS_POL;
    end
    if ((v_cnt_r >= VW'(V_ACTIVE + V_FP)) && (v_cnt_r < VW'(V_ACTIVE + V_FP + V_SYNC))) begin
      ctrl_s[C_VS] = VS_POL;
    end else begin
      ctrl_s[C_VS] = ~VS_POL;
    end
    ctrl_s[C_HB] = ~h_vis_s;
    ctrl_s[C_VB] = ~v_vis_s;
    ctrl_s[C_DE] = vis_s;
    ctrl_s[C_FS] = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
  end

  // Delay line aligning the control flags with the returned pixel data.
  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int i = 0; i < DLY; i++) begin
        ctrl_pipe_r[i] <= CTRL_IDLE;
      end
    end else begin
      ctrl_pipe_r[0] <= ctrl_s;
      for (int i = 1; i < DLY; i++) begin
        ctrl_pipe_r[i] <= ctrl_pipe_r[i-1];
      end
    end
  end

  // Colour expansion by bit replication for the selected pixel format.
  generate
    if (BPP == 24) begin : g_rgb888
      assign rgb_exp_s = fb_data;
    end else if (BPP == 16) begin : g_rgb565
      assign rgb_exp_s = {fb_data[15:11], fb_data[15:13],
                          fb_data[10:5],  fb_data[10:9],
                          fb_data[4:0],   fb_data[4:2]};
    end else begin : g_rgb332
      assign rgb_exp_s = {fb_data[7:5], fb_data[7:5], fb_data[7:6],
                          fb_data[4:2], fb_data[4:2], fb_data[4:3],
                          {4{fb_data[1:0]}}};
    end
  endgenerate

  // Colour register: stage RD_LAT of the delay line lines up with fb_data.
  always_ff @(posedge pclk) begin
    if (reset) begin
      rgb_r <= 24'h000000;
    end else if (ctrl_pipe_r[RD_LAT][C_DE]) begin
      rgb_r <= rgb_exp_s;
    end else begin
      rgb_r <= 24'h000000;
    end
  end

  assign r           = rgb_r[23:16];
  assign g           = rgb_r[15:8];
  assign b           = rgb_r[7:0];
  assign hs          = ctrl_pipe_r[DLY-1][C_HS];
  assign vs          = ctrl_pipe_r[DLY-1][C_VS];
  assign VGA_HB      = ctrl_pipe_r[DLY-1][C_HB];
  assign VGA_VB      = ctrl_pipe_r[DLY-1][C_VB];
  assign VGA_DE      = ctrl_pipe_r[DLY-1][C_DE];
  assign frame_start = ctrl_pipe_r[DLY-1][C_FS];

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout -- directed bench for vga_scanout.
// Small timings: H 8/2/2/2 (14 cycles), V 4/1/1/1 (7 lines), 2x2 scale,
// RGB332, RD_LAT=2 (end-to-end latency 4). Expected values come from the
// frame layout and a per-frame schedule of fb_base / memory contents.

module tb_vga_scanout;

  localparam int H_TOT = 14;
  localparam int F_TOT = 98;
  localparam int LAT   = 4;
`ifdef VGA_SCANOUT_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        reset;
  logic [17:0] fb_base;
  logic        fb_rd;
  logic [17:0] fb_addr;
  logic [7:0]  fb_data;
  logic        hs, vs, hb, vb, de, fs;
  logic [7:0]  r, g, b;
`ifdef VGA_SCANOUT_DBUF_EN
  logic [17:0] fb_base_alt;
  logic        swap_req;
  logic        swap_ack;
  logic        buf_sel;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          k     = 0;
  int          seg   = 0;
  logic [17:0] exp_addr;
  logic        mem_const;
  logic [17:0] d1_r, d2_r;

  always #5 pclk = ~pclk;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .SCALE_X(2), .SCALE_Y(2),
    .BPP(8), .ADDR_W(18), .RD_LAT(2)
  ) dut (
    .pclk(pclk),
    .reset(reset),
    .fb_base(fb_base),
`ifdef VGA_SCANOUT_DBUF_EN
    .fb_base_alt(fb_base_alt),
    .swap_req(swap_req),
    .swap_ack(swap_ack),
    .buf_sel(buf_sel),
`endif
    .fb_rd(fb_rd),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .hs(hs),
    .vs(vs),
    .r(r),
    .g(g),
    .b(b),
    .VGA_HB(hb),
    .VGA_VB(vb),
    .VGA_DE(de),
    .frame_start(fs)
  );

  // Framebuffer model with two cycles of read latency.
  always @(posedge pclk) begin
    d1_r <= fb_addr;
    d2_r <= d1_r;
  end
  assign fb_data = mem_const ? 8'hE0 : (d2_r[7:0] ^ 8'hA5);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d, seg %0d)", tag, got, exp, k, seg);
    end
  endtask

  function automatic bit vis_at(input int c);
    int h;
    int v;
    h = c % H_TOT;
    v = (c % F_TOT) / H_TOT;
    return (h < 8) && (v < 4);
  endfunction

  function automatic logic [17:0] base_of(input int f);
    if (seg == 1) return 18'h200;
    if (f >= 4) return DBUF ? 18'h300 : 18'h200;
    if (f >= 2) return 18'h200;
    return 18'h100;
  endfunction

  function automatic logic [17:0] addr_of(input int c);
    int h;
    int v;
    h = c % H_TOT;
    v = (c % F_TOT) / H_TOT;
    return base_of(c / F_TOT) + 18'((v / 2) * 4 + h / 2);
  endfunction

  function automatic logic [23:0] exp332(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
  endfunction

  task automatic check_idle();
    chk("rst_hs", hs, 1'b1);
    chk("rst_vs", vs, 1'b0);
    chk("rst_hb", hb, 1'b1);
    chk("rst_vb", vb, 1'b1);
    chk("rst_de", de, 1'b0);
    chk("rst_fs", fs, 1'b0);
    chk("rst_rgb", {r, g, b}, 24'h000000);
    chk("rst_fb_rd", fb_rd, 1'b0);
    chk("rst_fb_addr", fb_addr, 18'h0);
`ifdef VGA_SCANOUT_DBUF_EN
    chk("rst_buf_sel", buf_sel, 1'b0);
    chk("rst_swap_ack", swap_ack, 1'b0);
`endif
  endtask

  // Check every output k cycles after the last reset edge.
  task automatic check_cycle();
    int kc;
    int ko;
    int h;
    int v;
    logic        e_de;
    logic [7:0]  d;
    logic [23:0] e_rgb;
    kc = k - 1;
    chk("fb_rd", fb_rd, vis_at(kc));
    if (vis_at(kc)) exp_addr = addr_of(kc);
    chk("fb_addr", fb_addr, exp_addr);
    ko = k - LAT;
    if (ko < 0) begin
      chk("pre_de", de, 1'b0);
      chk("pre_fs", fs, 1'b0);
      chk("pre_hs", hs, 1'b1);
      chk("pre_rgb", {r, g, b}, 24'h000000);
    end else begin
      h    = ko % H_TOT;
      v    = (ko % F_TOT) / H_TOT;
      e_de = (h < 8) && (v < 4);
      chk("hs", hs, !((h >= 10) && (h < 12)));
      chk("vs", vs, (v == 5));
      chk("hb", hb, (h >= 8));
      chk("vb", vb, (v >= 4));
      chk("de", de, e_de);
      chk("fs", fs, (h == 0) && (v == 0));
      if (!e_de) begin
        e_rgb = 24'h000000;
      end else if ((seg == 0) && (ko / F_TOT == 1)) begin
        e_rgb = 24'hFF0000;
      end else begin
        d     = addr_of(ko) & 18'h0FF;
        e_rgb = exp332(d ^ 8'hA5);
      end
      chk("rgb", {r, g, b}, e_rgb);
    end
`ifdef VGA_SCANOUT_DBUF_EN
    chk("swap_ack", swap_ack, (seg == 0) && (k == 4 * F_TOT));
    chk("buf_sel", buf_sel, (seg == 0) && (k >= 4 * F_TOT));
`endif
  endtask

  initial begin
    reset     = 1'b1;
    fb_base   = 18'h100;
    mem_const = 1'b0;
    exp_addr  = 18'h0;
`ifdef VGA_SCANOUT_DBUF_EN
    fb_base_alt = 18'h300;
    swap_req    = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk);
      #1;
      check_idle();
    end
    reset = 1'b0;

    // Segment 0: five frames and a bit, with base change, colour frame, swap.
    seg = 0;
    for (int i = 1; i <= 520; i++) begin
      @(posedge pclk);
      #1;
      k = i;
      check_cycle();
      if (k % F_TOT == 0) mem_const = (k / F_TOT == 1);
      if (k == 128) fb_base = 18'h200;
`ifdef VGA_SCANOUT_DBUF_EN
      if (k == 314) swap_req = 1'b1;
      else if (swap_ack || (k == 420)) swap_req = 1'b0;
`endif
    end

    // Mid-frame reset, then restart exactly as after power-up.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk);
      #1;
    end
    check_idle();
    reset    = 1'b0;
    seg      = 1;
    exp_addr = 18'h0;
    for (int i = 1; i <= 110; i++) begin
      @(posedge pclk);
      #1;
      k = i;
      check_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
